// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the round-robin resource arbiter.
package arb_pkg;

    localparam int unsigned STATE_W      = 2;
    localparam int unsigned HOLD_W       = 8;
    localparam int unsigned HOLD_MAX_DEF = 16;
    localparam int unsigned N_REQ_MAX    = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // One-hot vector with bit idx set; all-zero when idx is out of range.
    function automatic logic [N_REQ_MAX-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [N_REQ_MAX-1:0] v;
        v = N_REQ_MAX'(1) << idx;
        if (idx >= n) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority selector: first set request at ptr, ptr+1, ... (mod N_REQ).
module rr_priority_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [IDW-1:0]   winner_o,
    output logic             any_req_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDW:0]       sum;

    // Rotate so bit k is the request at offset k from ptr; lowest offset wins.
    always_comb begin
        dbl       = {req_i, req_i} >> ptr_i;
        rot       = N_REQ'(dbl);
        winner_o  = '0;
        any_req_o = 1'b0;
        sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N_REQ)) begin
                    sum = sum - (IDW+1)'(N_REQ);
                end
                winner_o  = IDW'(sum);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin single-owner resource arbiter (IDLE -> GRANT -> GAP Mealy FSM).
// Define ARB_REG_OUT_EN to register gnt/gnt_id/timeout through one D-FF stage.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned HOLD_MAX = HOLD_MAX_DEF,
    localparam int unsigned IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             timeout
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [IDW-1:0]      winner;
    logic                any_req;
    logic [IDW-1:0]      ptr_next;

    logic [N_REQ-1:0]    gnt_c;
    logic [IDW-1:0]      gnt_id_c;
    logic                timeout_c;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign ptr_next = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);

    // State, pointer, owner and hold counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state and Mealy outputs; reset forces outputs low in the same cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gnt_c      = '0;
        gnt_id_c   = '0;
        timeout_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_c      = N_REQ'(onehot(32'(winner), N_REQ));
                    gnt_id_c   = winner;
                    owner_d    = winner;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel || !req[owner_q]) begin
                    ptr_d   = ptr_next;
                    state_d = ST_GAP;
                end else if (hold_cnt_q == HOLD_W'(HOLD_MAX - 1)) begin
                    timeout_c = 1'b1;
                    ptr_d     = ptr_next;
                    state_d   = ST_GAP;
                end else begin
                    gnt_c      = N_REQ'(onehot(32'(owner_q), N_REQ));
                    gnt_id_c   = owner_q;
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            gnt_c     = '0;
            gnt_id_c  = '0;
            timeout_c = 1'b0;
        end
    end

`ifdef ARB_REG_OUT_EN
    logic [N_REQ-1:0] gnt_q;
    logic [IDW-1:0]   gnt_id_q;
    logic             timeout_q;

    // Glitch-free output stage, one cycle behind the Mealy values.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_c;
            gnt_id_q  <= gnt_id_c;
            timeout_q <= timeout_c;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;
`else
    assign gnt     = gnt_c;
    assign gnt_id  = gnt_id_c;
    assign timeout = timeout_c;
`endif

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
Round-robin arbiter that shares one single-owner resource (for example a UART transmitter or a shared bus port) between N_REQ requesters.
- Built as a 3-state Mealy FSM: a grant follows the request combinationally and is dropped on release, request withdrawal or hold timeout.
- A one-cycle gap separates any two consecutive grants.
- Sits between the requesting client FSMs and the resource's enable/select mux.

Parameters:
N_REQ, 4, number of requesters (1..16)
HOLD_MAX, 16, maximum total cycles a grant may stay high before forced release (2..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level; must stay high while owning
rel  in  1  release strobe from the current owner; sampled only in GRANT
gnt  out  N_REQ  one-hot grant, all-zero when no owner
gnt_id  out  max(1,clog2(N_REQ))  index of the granted requester; 0 when gnt is all-zero
timeout  out  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- State registers: state (IDLE=0, GRANT=1, GAP=2), ptr (round-robin start index), owner, hold_cnt (8 bit).
- Reset: state=IDLE, ptr=0, owner=0, hold_cnt=0. While reset=1, all outputs are forced 0 combinationally.
- Reset mid-grant: gnt drops in the same cycle; no timeout pulse is generated.
- IDLE:
  - If req is nonzero, the winner is the first set bit at index ptr, ptr+1, ... (mod N_REQ).
  - In that same cycle: gnt=onehot(winner), gnt_id=winner. Next cycle: owner<=winner, hold_cnt<=0, state<=GRANT.
  - If req is zero: outputs 0, stay in IDLE.
- GRANT, conditions in priority order:
  - Normal release (rel=1, or req[owner]=0, or both): gnt=0 this cycle; timeout=0; ptr<=(owner+1) mod N_REQ; state<=GAP.
  - Timeout (hold_cnt==HOLD_MAX-1 with no normal release): gnt=0, timeout=1; ptr<=(owner+1) mod N_REQ; state<=GAP.
  - Otherwise: gnt=onehot(owner), gnt_id=owner, hold_cnt<=hold_cnt+1.
  - A grant is therefore high for at most HOLD_MAX consecutive cycles.
- GAP: all outputs 0; state<=IDLE. The gap cycle is unconditional, even if req is pending.
- rel is ignored in IDLE and GAP. A rel in the IDLE grant cycle does not shorten the grant.
- ptr wraps from N_REQ-1 to 0. With N_REQ=1, ptr stays 0.
- gnt is always one-hot or zero. gnt_id always equals the index of the set gnt bit.
- Unused state encoding 3 returns to IDLE on the next cycle, with outputs 0.

Optional Feature:
Macro ARB_REG_OUT_EN.
- Defined: gnt, gnt_id and timeout pass through an output D-FF stage. Every output appears exactly one cycle later than the combinational values above, is glitch-free, and resets to 0 synchronously. FSM timing is unchanged.
- Undefined: outputs are the combinational Mealy values, with zero-cycle request-to-grant latency.

Decomposition:
- Package arb_pkg holds:
  - the state localparams (ST_IDLE, ST_GRANT, ST_GAP) and the 2-bit state width;
  - the default HOLD_MAX;
  - a function onehot(idx, N).
- Sub-module rr_priority_pick: combinational rotate-priority selector. Inputs req and ptr; outputs winner index and any_req. The FSM and counters stay in the top module.

Test Plan:
- Reset and idle: reset=1 for 3 cycles with req=4'b1111 -> gnt=0, timeout=0 throughout. After reset falls: gnt=4'b0001 in the first cycle, gnt_id=0.
- Round-robin order: req=4'b1111, owner pulses rel on its 3rd GRANT cycle -> gnt_id sequence 0,1,2,3,0 with exactly one zero-gnt GAP cycle between grants.
- Request withdrawal: req[2] alone, dropped after 5 cycles -> gnt[2] falls in the same cycle as req[2]; GAP follows; next winner search starts at index 3.
- Timeout: HOLD_MAX=16, req[1] held high, rel=0 -> gnt[1] high 16 consecutive cycles, then timeout=1 for one cycle with gnt=0. Then GAP, then gnt[1] again only if no other request is pending.
- Simultaneous release and timeout: rel=1 in the cycle where hold_cnt=HOLD_MAX-1 -> timeout stays 0; normal release path is taken.
- ARB_REG_OUT_EN defined: rerun the round-robin scenario -> identical sequence shifted by exactly one cycle, with no combinational path from req to gnt.
